fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller.
// Issues one instruction-memory request at a time from the PC register,
// waits for the read data, and hands the instruction to decode with a
// valid/ready handshake. Exception and jump redirects retarget the PC at
// any point; a response belonging to a superseded request is dropped.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   imem_req     : request valid (REQ state, no stale response pending)
//   imem_addr    : request address (current PC)
//   imem_gnt     : memory accepted the request this cycle
//   imem_rvalid  : read data valid
//   imem_rdata   : instruction word
//   exc, exc_vec : exception redirect and its target
//   jmp, jmp_pc  : branch/jump redirect and its target
//   out_valid    : instruction available to decode
//   out_ready    : decode accepts
//   out_pc       : PC of out_instr
//   out_instr    : fetched instruction
//   fetch_cnt    : number of delivered instructions
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        exc,
  input  logic [31:0] exc_vec,
  input  logic        jmp,
  input  logic [31:0] jmp_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {REQ, WAIT, OUT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        discard;
  // Set while in reset if a response is still owed by memory; folded into
  // discard on the first cycle after reset release.
  logic        rst_pend;
  logic        rst_q;

  logic        redir;
  logic [31:0] tgt;
  logic        stale;
  logic        owed;

  function automatic logic [31:0] align_tgt(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  assign redir = exc | jmp;
  assign tgt   = align_tgt(exc ? exc_vec : jmp_pc);
  // A stale response is outstanding: either a redirected request in flight
  // or one left behind by a reset.
  assign stale = discard | rst_pend;

  // No new request may be issued while a stale response is still owed,
  // keeping a single request outstanding.
  assign imem_req  = (state == REQ) && !stale;
  assign imem_addr = pc;
  assign out_valid = (state == OUT);

  // Response owed by memory at this edge, excluding one that completes now.
  assign owed = (((state == WAIT) || ((state == REQ) && stale)) && !imem_rvalid)
              || (imem_req && imem_gnt);

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      fetch_cnt <= 32'd0;
      out_pc    <= 32'd0;
      out_instr <= 32'd0;
      // Sample outstanding state on the first reset cycle, then only watch
      // for the late response completing during a long reset.
      rst_pend  <= rst_q ? (rst_pend && !imem_rvalid) : owed;
    end else begin
      rst_pend <= 1'b0;
      case (state)
        REQ: begin
          if (stale) begin
            discard <= !imem_rvalid;
            if (redir) pc <= tgt;
          end else if (imem_gnt) begin
            inflight_pc <= pc;
            state       <= WAIT;
            discard     <= redir;
            if (redir) pc <= tgt;
          end else if (redir) begin
            pc <= tgt;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (redir) pc <= tgt;
            if (stale || redir) begin
              state <= REQ;
            end else begin
              out_instr <= imem_rdata;
              out_pc    <= inflight_pc;
              state     <= OUT;
            end
          end else if (redir) begin
            pc      <= tgt;
            discard <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) fetch_cnt <= fetch_cnt + 32'd1;
          // Redirect beats the sequential increment.
          if (redir) begin
            pc    <= tgt;
            state <= REQ;
          end else if (out_ready) begin
            pc    <= pc + STEP;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        exc;
  logic [31:0] exc_vec;
  logic        jmp;
  logic [31:0] jmp_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] fetch_cnt;

  int tests = 0;
  int fails = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .exc(exc), .exc_vec(exc_vec), .jmp(jmp), .jmp_pc(jmp_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Full REQ -> WAIT -> OUT -> transfer cycle at address a.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] cnt_before);
    chk("req_hi", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, a);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_req_lo", {31'd0, imem_req}, 32'd0);
    chk("wait_valid_lo", {31'd0, out_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word_of(a);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hxxxx_xxxx;
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_pc", out_pc, a);
    chk("out_instr", out_instr, word_of(a));
    chk("cnt_before", fetch_cnt, cnt_before);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("cnt_after", fetch_cnt, cnt_before + 32'd1);
    chk("post_valid_lo", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    exc = 1'b0; exc_vec = 32'd0; jmp = 1'b0; jmp_pc = 32'd0; out_ready = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst = 1'b0;
    chk("rel_valid", {31'd0, out_valid}, 32'd0);

    // Sequential fetch 0,4,8,C
    fetch_one(32'h0, 32'd0);
    fetch_one(32'h4, 32'd1);
    fetch_one(32'h8, 32'd2);
    fetch_one(32'hC, 32'd3);
    chk("cnt4", fetch_cnt, 32'd4);

    // Backpressure at 0x10
    chk("bp_addr", imem_addr, 32'h10);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = word_of(32'h10); tick(); imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_pc", out_pc, 32'h10);
      chk("bp_instr", out_instr, word_of(32'h10));
      chk("bp_req_lo", {31'd0, imem_req}, 32'd0);
      chk("bp_cnt", fetch_cnt, 32'd4);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_cnt5", fetch_cnt, 32'd5);
    chk("bp_next_addr", imem_addr, 32'h14);

    // Jump while in WAIT: response dropped, target aligned
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    jmp = 1'b1; jmp_pc = 32'h0000_0103; tick(); jmp = 1'b0;
    chk("jw_req_lo", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0014; tick(); imem_rvalid = 1'b0;
    chk("jw_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("jw_req", {31'd0, imem_req}, 32'd1);
    chk("jw_addr", imem_addr, 32'h100);
    chk("jw_cnt", fetch_cnt, 32'd5);

    // exc + jmp in OUT with transfer: exception wins, transfer counts
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = word_of(32'h100); tick(); imem_rvalid = 1'b0;
    chk("eo_pc", out_pc, 32'h100);
    exc = 1'b1; exc_vec = 32'h80; jmp = 1'b1; jmp_pc = 32'h200; out_ready = 1'b1;
    tick();
    exc = 1'b0; jmp = 1'b0; out_ready = 1'b0;
    chk("eo_cnt", fetch_cnt, 32'd6);
    chk("eo_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("eo_addr", imem_addr, 32'h80);

    // Redirect coincident with rvalid in WAIT
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0080; jmp = 1'b1; jmp_pc = 32'h300;
    tick();
    imem_rvalid = 1'b0; jmp = 1'b0;
    chk("rv_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("rv_req", {31'd0, imem_req}, 32'd1);
    chk("rv_addr", imem_addr, 32'h300);

    // Redirect coincident with grant in REQ
    imem_gnt = 1'b1; jmp = 1'b1; jmp_pc = 32'h400; tick();
    imem_gnt = 1'b0; jmp = 1'b0;
    chk("rg_req_lo", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0300; tick(); imem_rvalid = 1'b0;
    chk("rg_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("rg_addr", imem_addr, 32'h400);
    fetch_one(32'h400, 32'd6);

    // Redirect in REQ without grant, unaligned exception vector
    exc = 1'b1; exc_vec = 32'h0000_0557; tick(); exc = 1'b0;
    chk("rq_req", {31'd0, imem_req}, 32'd1);
    chk("rq_addr", imem_addr, 32'h554);

    // Redirect in OUT without transfer: instruction dropped
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = word_of(32'h554); tick(); imem_rvalid = 1'b0;
    chk("ro_valid", {31'd0, out_valid}, 32'd1);
    jmp = 1'b1; jmp_pc = 32'h600; tick(); jmp = 1'b0;
    chk("ro_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("ro_cnt", fetch_cnt, 32'd7);
    chk("ro_addr", imem_addr, 32'h600);

    // PC wrap
    jmp = 1'b1; jmp_pc = 32'hFFFF_FFFC; tick(); jmp = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'd7);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset in WAIT, late response 3 cycles after reset
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rw_cnt", fetch_cnt, 32'd0);
    chk("rw_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("rw_req_lo0", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rw_req_lo1", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rw_req_lo2", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000; tick(); imem_rvalid = 1'b0;
    chk("rw_valid_lo2", {31'd0, out_valid}, 32'd0);
    chk("rw_cnt2", fetch_cnt, 32'd0);
    fetch_one(32'h0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
